// File: rtl/tetris_input_ctrl.sv
// Input front end for the tetris core: debounces buttons, auto-repeats moves, times gravity
// and hands the core one prioritised command per ready handshake.
module tetris_input_ctrl #(
    parameter int unsigned DEB_CYCLES   = 100000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned GRAVITY_BASE = 50000000,
    parameter int unsigned GRAVITY_STEP = 4000000,
    parameter int unsigned GRAVITY_MIN  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn,
    input  logic [3:0] level,
    input  logic       pause,
    input  logic       ready,
    output logic [2:0] ctrl,
    output logic       gravity
);
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast  = DebW'(DEB_CYCLES - 1);
    localparam logic [31:0]     RepFirst = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0]     RepNext  = 32'(REPEAT_RATE - 1);
    localparam logic [35:0]     GravBase = 36'(GRAVITY_BASE);
    localparam logic [31:0]     GravMin  = 32'(GRAVITY_MIN);

    localparam logic [2:0] CmdNone  = 3'd0;
    localparam logic [2:0] CmdLeft  = 3'd1;
    localparam logic [2:0] CmdRight = 3'd2;
    localparam logic [2:0] CmdRot   = 3'd3;
    localparam logic [2:0] CmdDown  = 3'd4;
    localparam logic [2:0] CmdDrop  = 3'd5;
    localparam logic [2:0] CmdHold  = 3'd6;

    typedef enum logic [1:0] {StRun, StWait, StPause} state_e;

    state_e                 state_q, state_d;
    logic [5:0]             sync1_q, sync2_q, deb_q, deb_d, press;
    logic [5:0][DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [2:0][31:0]       rep_cnt_q, rep_cnt_d;
    logic [2:0]             rep_armed_q, rep_armed_d, rep_fire;
    logic [31:0]            grav_cnt_q, grav_cnt_d, grav_raw, period;
    logic [35:0]            grav_drop;
    logic                   grav_tick, gravity_q;
    // Pending flags are indexed by command code; bit 0 is the gravity request.
    logic [6:0]             pend_q, pend_d, carry_q, carry_d, set, clr;
    logic [2:0]             win, ctrl_q, ctrl_d;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press     = '0;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // LEFT/RIGHT/DOWN occupy btn[2:0]; the first repeat waits longer than later ones.
    always_comb begin
        rep_cnt_d   = '0;
        rep_armed_d = '0;
        rep_fire    = '0;
        for (int i = 0; i < 3; i++) begin
            if (deb_q[i]) begin
                if (rep_cnt_q[i] == (rep_armed_q[i] ? RepNext : RepFirst)) begin
                    rep_fire[i]    = 1'b1;
                    rep_armed_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i]   = rep_cnt_q[i] + 32'd1;
                    rep_armed_d[i] = rep_armed_q[i];
                end
            end
        end
    end

    always_comb begin
        grav_drop = 36'(level) * 36'(GRAVITY_STEP);
        grav_raw  = (grav_drop >= GravBase) ? 32'd0 : 32'(GravBase - grav_drop);
        period    = (grav_raw < GravMin) ? GravMin : grav_raw;
        grav_tick  = 1'b0;
        grav_cnt_d = grav_cnt_q;
        if (!pause) begin
            if (grav_cnt_q >= period - 32'd1) begin
                grav_tick  = 1'b1;
                grav_cnt_d = '0;
            end else begin
                grav_cnt_d = grav_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        set = {press[5], press[4], press[2] | rep_fire[2], press[3],
               press[1] | rep_fire[1], press[0] | rep_fire[0], grav_tick};

        if (pend_q[CmdHold])                  win = CmdHold;
        else if (pend_q[CmdDrop])             win = CmdDrop;
        else if (pend_q[CmdRot])              win = CmdRot;
        else if (pend_q[CmdLeft])             win = CmdLeft;
        else if (pend_q[CmdRight])            win = CmdRight;
        else if (pend_q[CmdDown] | pend_q[0]) win = CmdDown;
        else                                  win = CmdNone;

        state_d = state_q;
        ctrl_d  = CmdNone;
        clr     = '0;
        unique case (state_q)
            StRun: begin
                if (pause) begin
                    state_d = StPause;
                end else if (ready && win != CmdNone) begin
                    ctrl_d  = win;
                    clr     = (win == CmdDown) ? 7'b001_0001 : (7'd1 << win);
                    state_d = StWait;
                end
            end
            StWait:  if (ready) state_d = pause ? StPause : StRun;
            StPause: if (!pause) state_d = StRun;
            default: state_d = StRun;
        endcase

        // An event colliding with its own issue is replayed one cycle later.
        if (pause) begin
            pend_d  = '0;
            carry_d = '0;
        end else begin
            pend_d  = ((pend_q | set) & ~clr) | carry_q;
            carry_d = set & clr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= '0;
            grav_cnt_q  <= '0;
            pend_q      <= '0;
            carry_q     <= '0;
            state_q     <= StRun;
            ctrl_q      <= CmdNone;
            gravity_q   <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
            carry_q     <= carry_d;
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            gravity_q   <= grav_tick;
        end
    end

    assign ctrl    = ctrl_q;
    assign gravity = gravity_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed scenarios plus a randomised run, all tracked every
// cycle by a behavioural model of the button/gravity/arbitration rules.
module tb_tetris_input_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RR  = 3;
    localparam int GB  = 20;
    localparam int GS  = 4;
    localparam int GM  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn;
    logic [3:0] level;
    logic       pause;
    logic       ready;
    logic [2:0] ctrl;
    logic       gravity;

    always #5 clk = ~clk;

    tetris_input_ctrl #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .GRAVITY_BASE(GB),
        .GRAVITY_STEP(GS),
        .GRAVITY_MIN (GM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .level  (level),
        .pause  (pause),
        .ready  (ready),
        .ctrl   (ctrl),
        .gravity(gravity)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int base    = 0;

    // Button index -> command code, and command priority order (highest first).
    int cmd_of [6] = '{1, 2, 4, 3, 5, 6};
    int prio   [6] = '{6, 5, 3, 1, 2, 4};

    bit       m_s1 [6];
    bit       m_s2 [6];
    bit       m_deb[6];
    int       m_dcnt[6];
    int       m_held[3];
    int       m_g;
    bit [6:0] m_pend;
    bit [6:0] m_defer;
    int       m_state;  // 0 run, 1 wait, 2 pause
    int       m_ctrl;
    bit       m_grav;

    task automatic model_edge();
        bit [6:0] ev;
        bit [6:0] clr;
        int       per;
        int       win;
        int       h;
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_dcnt[i] = 0;
            end
            for (int i = 0; i < 3; i++) m_held[i] = 0;
            m_g = 0; m_pend = '0; m_defer = '0; m_state = 0; m_ctrl = 0; m_grav = 0;
            return;
        end
        ev = '0;
        // Held move buttons fire at RD cycles of holding, then every RR cycles.
        for (int i = 0; i < 3; i++) begin
            if (m_deb[i]) begin
                h = m_held[i] + 1;
                if (h == RD || (h > RD && (h - RD) % RR == 0)) ev[cmd_of[i]] = 1'b1;
                m_held[i] = h;
            end else begin
                m_held[i] = 0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (m_s2[i] == m_deb[i]) begin
                m_dcnt[i] = 0;
            end else if (m_dcnt[i] == DEB - 1) begin
                m_deb[i]  = m_s2[i];
                m_dcnt[i] = 0;
                if (m_s2[i]) ev[cmd_of[i]] = 1'b1;
            end else begin
                m_dcnt[i] = m_dcnt[i] + 1;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn[i];
        end
        per = GB - int'(level) * GS;
        if (per < GM) per = GM;
        m_grav = 0;
        if (!pause) begin
            if (m_g >= per - 1) begin
                m_g = 0; m_grav = 1; ev[0] = 1'b1;
            end else begin
                m_g = m_g + 1;
            end
        end
        win = 0;
        for (int k = 0; k < 6; k++)
            if (win == 0 && (m_pend[prio[k]] || (prio[k] == 4 && m_pend[0]))) win = prio[k];
        clr = '0;
        m_ctrl = 0;
        case (m_state)
            0: begin
                if (pause) m_state = 2;
                else if (ready && win != 0) begin
                    m_ctrl = win; clr[win] = 1'b1;
                    if (win == 4) clr[0] = 1'b1;
                    m_state = 1;
                end
            end
            1: if (ready) m_state = pause ? 2 : 0;
            default: if (!pause) m_state = 0;
        endcase
        if (pause) begin
            m_pend = '0; m_defer = '0;
        end else begin
            m_pend  = ((m_pend | ev) & ~clr) | m_defer;
            m_defer = ev & clr;
        end
    endtask

    task automatic step();
        logic rdy;
        rdy = ready;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        n_total++;
        if (ctrl !== 3'(m_ctrl))
            $display("FAIL model_ctrl cyc=%0d got=%0d want=%0d", cyc, ctrl, m_ctrl);
        else n_pass++;
        n_total++;
        if (gravity !== m_grav)
            $display("FAIL model_gravity cyc=%0d got=%0b want=%0b", cyc, gravity, m_grav);
        else n_pass++;
        if (ctrl !== 3'd0) begin
            n_total++;
            if (rdy !== 1'b1)
                $display("FAIL ctrl_without_ready cyc=%0d got ctrl=%0d want 0", cyc, ctrl);
            else n_pass++;
        end
    endtask

    task automatic do_reset();
        reset = 1; btn = '0; pause = 0; ready = 0; level = '0;
        step();
        step();
        reset = 0;
        base = cyc;
    endtask

    task automatic test_reset();
        reset = 1; btn = 6'($urandom); pause = 0; ready = 1; level = '0;
        repeat (3) step();
        n_total++;
        if (ctrl !== 3'd0) $display("FAIL reset_ctrl got=%0d want=0", ctrl); else n_pass++;
        n_total++;
        if (gravity !== 1'b0) $display("FAIL reset_gravity got=%0b want=0", gravity);
        else n_pass++;
        reset = 0; btn = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_total++;
            if (ctrl !== 3'd0) $display("FAIL post_reset_idle got=%0d want=0", ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int t_stable, t_first, n_left;
        do_reset();
        ready = 1;
        btn[0] = 1; step();
        btn[0] = 0; step();
        btn[0] = 1;
        t_stable = cyc + 1;
        t_first = -1; n_left = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 6) btn[0] = 0;
            step();
            if (ctrl === 3'd1) begin
                n_left++;
                if (t_first < 0) t_first = cyc;
            end
        end
        n_total++;
        if (n_left != 1) $display("FAIL bounce_count got=%0d want=1", n_left); else n_pass++;
        n_total++;
        if (t_first < t_stable + 6)
            $display("FAIL bounce_latency got=%0d want>=%0d", t_first, t_stable + 6);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int n_right, t0, t1;
        do_reset();
        ready = 1;
        btn[1] = 1;
        n_right = 0; t0 = -1; t1 = -1;
        for (int k = 0; k < 43; k++) begin
            if (k == 18) btn[1] = 0;
            step();
            if (ctrl === 3'd2) begin
                n_right++;
                if (t0 < 0) t0 = cyc; else if (t1 < 0) t1 = cyc;
            end
        end
        n_total++;
        if (n_right != 5) $display("FAIL repeat_count got=%0d want=5", n_right); else n_pass++;
        n_total++;
        if (t1 - t0 != RD) $display("FAIL repeat_first_gap got=%0d want=%0d", t1 - t0, RD);
        else n_pass++;
    endtask

    task automatic test_gravity();
        int lvls [3] = '{0, 4, 15};
        int pers [3] = '{20, 6, 6};
        int t1, t2;
        for (int j = 0; j < 3; j++) begin
            do_reset();
            level = 4'(lvls[j]); ready = 1;
            t1 = -1; t2 = -1;
            for (int k = 0; k < 60 && t2 < 0; k++) begin
                step();
                if (t1 >= 0 && cyc == t1 + 1) begin
                    n_total++;
                    if (ctrl !== 3'd4) $display("FAIL gravity_down lvl=%0d got=%0d want=4",
                                                lvls[j], ctrl);
                    else n_pass++;
                end
                if (gravity === 1'b1) begin
                    if (t1 < 0) t1 = cyc; else t2 = cyc;
                end
            end
            n_total++;
            if (t1 - base != pers[j])
                $display("FAIL gravity_first lvl=%0d got=%0d want=%0d", lvls[j], t1 - base, pers[j]);
            else n_pass++;
            n_total++;
            if (t2 - t1 != pers[j])
                $display("FAIL gravity_period lvl=%0d got=%0d want=%0d", lvls[j], t2 - t1, pers[j]);
            else n_pass++;
        end
        // Shrinking the period below the current count fires on the very next cycle.
        do_reset();
        ready = 1;
        repeat (15) step();
        level = 4'd15;
        step();
        n_total++;
        if (gravity !== 1'b1) $display("FAIL gravity_level_jump got=%0b want=1", gravity);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int vals [3];
        int ts   [3];
        int n;
        do_reset();
        btn = 6'b111000;
        repeat (16) step();
        ready = 1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ctrl !== 3'd0 && n < 3) begin
                vals[n] = int'(ctrl); ts[n] = cyc; n++;
            end
        end
        btn = '0;
        n_total++;
        if (n != 3) $display("FAIL prio_count got=%0d want=3", n); else n_pass++;
        if (n == 3) begin
            n_total++;
            if (vals[0] != 6 || vals[1] != 5 || vals[2] != 3)
                $display("FAIL prio_order got=%0d,%0d,%0d want=6,5,3", vals[0], vals[1], vals[2]);
            else n_pass++;
            n_total++;
            if (ts[1] - ts[0] != 2 || ts[2] - ts[1] != 2)
                $display("FAIL prio_spacing got=%0d,%0d want=2,2", ts[1] - ts[0], ts[2] - ts[1]);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        int tg, n_rot;
        do_reset();
        btn[3] = 1;
        repeat (8) step();
        pause = 1; ready = 1; btn = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_total++;
            if (ctrl !== 3'd0 || gravity !== 1'b0)
                $display("FAIL pause_quiet got ctrl=%0d grav=%0b want 0/0", ctrl, gravity);
            else n_pass++;
        end
        pause = 0;
        tg = -1; n_rot = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (gravity === 1'b1 && tg < 0) tg = cyc;
            if (ctrl === 3'd3) n_rot++;
        end
        n_total++;
        if (n_rot != 0) $display("FAIL pause_stale got=%0d want=0", n_rot); else n_pass++;
        n_total++;
        if (tg - base != 30) $display("FAIL pause_resume got=%0d want=30", tg - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_cmd;
        do_reset();
        btn = 6'b111001;
        repeat (12) step();
        ready = 1;
        step();
        n_total++;
        if (ctrl !== 3'd6) $display("FAIL midreset_issue got=%0d want=6", ctrl); else n_pass++;
        ready = 0;
        repeat (2) step();
        reset = 1; btn = '0;
        step();
        n_total++;
        if (ctrl !== 3'd0) $display("FAIL midreset_ctrl got=%0d want=0", ctrl); else n_pass++;
        reset = 0; ready = 1;
        n_cmd = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (ctrl !== 3'd0) n_cmd++;
        end
        n_total++;
        if (n_cmd != 0) $display("FAIL midreset_drop got=%0d want=0", n_cmd); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            for (int b = 0; b < 6; b++) if ($urandom_range(9) == 0) btn[b] = ~btn[b];
            ready = ($urandom_range(3) != 0);
            if ($urandom_range(39) == 0) pause = ~pause;
            if ($urandom_range(59) == 0) level = 4'($urandom_range(15));
            reset = ($urandom_range(399) == 0);
            step();
        end
        reset = 0; pause = 0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_gravity();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
